// File: rtl/axil_bram_pkg.sv
// AXI4-Lite to BRAM bridge: shared types and constants.
// FSM state enum, AXI response codes, default widths.
`timescale 1ns/1ps
package axil_bram_pkg;
    localparam int ADDR_W_DEF  = 16;
    localparam int BRAM_AW_DEF = 13;
    localparam int DATA_W      = 64;
    localparam int STRB_W      = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_RESP,
        WR_RESP
    } state_t;
endpackage

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave bridging single-beat accesses onto a 64-bit BRAM port.
// Ports: clock/resetn (async low), AXI-Lite AW/W/B/AR/R, bram_* storage port.
// Build option: AXIL_BRAM_WPROT_EN makes the memory write-protected
// (every write answered SLVERR, BRAM never written).
`timescale 1ns/1ps
module axil_bram_bridge
    import axil_bram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BRAM_AW = BRAM_AW_DEF
) (
    input  logic               clock,
    input  logic               resetn,

    input  logic               s_awvalid,
    output logic               s_awready,
    input  logic [ADDR_W-1:0]  s_awaddr,

    input  logic               s_wvalid,
    output logic               s_wready,
    input  logic [DATA_W-1:0]  s_wdata,
    input  logic [STRB_W-1:0]  s_wstrb,

    output logic               s_bvalid,
    input  logic               s_bready,
    output logic [1:0]         s_bresp,

    input  logic               s_arvalid,
    output logic               s_arready,
    input  logic [ADDR_W-1:0]  s_araddr,

    output logic               s_rvalid,
    input  logic               s_rready,
    output logic [DATA_W-1:0]  s_rdata,
    output logic [1:0]         s_rresp,

    output logic               bram_en,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic [DATA_W-1:0]  bram_wdata,
    output logic [STRB_W-1:0]  bram_we,
    input  logic [DATA_W-1:0]  bram_rdata
);

`ifdef AXIL_BRAM_WPROT_EN
    localparam state_t     WR_ENTRY = WR_RESP;
    localparam logic [1:0] WR_CODE  = RESP_SLVERR;
`else
    localparam state_t     WR_ENTRY = WRITE;
    localparam logic [1:0] WR_CODE  = RESP_OKAY;
`endif

    state_t              state, state_nx;
    logic [BRAM_AW-1:0]  addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rd_hold;
    logic                rd_first;
    logic [1:0]          bresp_q;
    logic                ar_hs;
    logic                wr_hs;
    logic                unused_addr;

    // Byte offset within the 64-bit word carries no information here.
    assign unused_addr = ^{s_awaddr[2:0], s_araddr[2:0]};

    always_comb begin
        state_nx  = state;
        s_arready = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_rvalid  = 1'b0;
        bram_en   = 1'b0;
        bram_we   = '0;
        ar_hs     = 1'b0;
        wr_hs     = 1'b0;
        unique case (state)
            IDLE: begin
                // Ready outputs stay low while reset is held.
                s_arready = resetn;
                ar_hs     = resetn && s_arvalid;
                // Read has priority; write waits with its data intact.
                wr_hs     = resetn && s_awvalid && s_wvalid && !s_arvalid;
                s_awready = wr_hs;
                s_wready  = wr_hs;
                if (ar_hs)
                    state_nx = RD_WAIT;
                else if (wr_hs)
                    state_nx = WR_ENTRY;
            end
            WRITE: begin
                bram_en  = 1'b1;
`ifdef AXIL_BRAM_WPROT_EN
                bram_we  = '0;
`else
                bram_we  = wstrb_q;
`endif
                state_nx = WR_RESP;
            end
            RD_WAIT: begin
                bram_en  = 1'b1;
                state_nx = RD_RESP;
            end
            RD_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready)
                    state_nx = IDLE;
            end
            WR_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rd_hold  <= '0;
            rd_first <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            state    <= state_nx;
            rd_first <= (state == RD_WAIT);
            if (ar_hs) begin
                addr_q  <= s_araddr[BRAM_AW+2:3];
            end else if (wr_hs) begin
                addr_q  <= s_awaddr[BRAM_AW+2:3];
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
                bresp_q <= WR_CODE;
            end
            if (rd_first)
                rd_hold <= bram_rdata;
        end
    end

    // First RD_RESP cycle forwards the BRAM output directly while the
    // holding register loads; afterwards the held copy keeps rdata stable.
    assign s_rdata    = rd_first ? bram_rdata : rd_hold;
    assign s_rresp    = RESP_OKAY;
    assign s_bresp    = s_bvalid ? bresp_q : RESP_OKAY;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Directed bench for axil_bram_bridge with a behavioural BRAM model.
// Expected values are hand-computed constants; build option aware.
`timescale 1ns/1ps
module tb_axil_bram_bridge;
    import axil_bram_pkg::*;

    localparam int TMO = 50;
`ifdef AXIL_BRAM_WPROT_EN
    localparam logic [1:0] WR_EXP = RESP_SLVERR;
    localparam int         WLAT   = 1;
    localparam bit         WP     = 1'b1;
`else
    localparam logic [1:0] WR_EXP = RESP_OKAY;
    localparam int         WLAT   = 2;
    localparam bit         WP     = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        s_awvalid, s_awready;
    logic [15:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [15:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        bram_en;
    logic [12:0] bram_addr;
    logic [63:0] bram_wdata;
    logic [7:0]  bram_we;
    logic [63:0] bram_rdata = '0;

    logic [63:0] mem [0:8191];
    int total = 0;
    int bad = 0;
    int excl_viol = 0;
    int we_seen = 0;

    always #5 clock = ~clock;

    axil_bram_bridge dut (
        .clock      (clock),
        .resetn     (resetn),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_awaddr   (s_awaddr),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .s_bresp    (s_bresp),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_araddr   (s_araddr),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_we    (bram_we),
        .bram_rdata (bram_rdata)
    );

    always @(posedge clock) begin
        if (bram_en) begin
            for (int i = 0; i < 8; i++)
                if (bram_we[i])
                    mem[bram_addr][8*i +: 8] <= bram_wdata[8*i +: 8];
            bram_rdata <= mem[bram_addr];
        end
    end

    always @(negedge clock) begin
        if (!bram_en && bram_we != 8'h00) excl_viol <= excl_viol + 1;
        if (bram_we != 8'h00) we_seen <= we_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [63:0] d,
                             input logic [7:0] st, output logic [1:0] resp,
                             output int lat);
        bit ok;
        s_awaddr  = a;
        s_wdata   = d;
        s_wstrb   = st;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clock);
            if (s_awready && s_wready) begin ok = 1'b1; break; end
        end
        check("aw_accept", 64'(ok), 64'd1);
        @(posedge clock); #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        lat  = 0;
        ok   = 1'b0;
        resp = 2'bxx;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clock);
            lat++;
            if (s_bvalid) begin ok = 1'b1; resp = s_bresp; break; end
        end
        check("b_seen", 64'(ok), 64'd1);
        @(posedge clock); #1;
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [63:0] d,
                            output logic [1:0] resp, output int lat);
        bit ok;
        s_araddr  = a;
        s_arvalid = 1'b1;
        s_rready  = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clock);
            if (s_arready) begin ok = 1'b1; break; end
        end
        check("ar_accept", 64'(ok), 64'd1);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        lat  = 0;
        ok   = 1'b0;
        d    = 'x;
        resp = 2'bxx;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clock);
            lat++;
            if (s_rvalid) begin
                ok = 1'b1; d = s_rdata; resp = s_rresp; break;
            end
        end
        check("r_seen", 64'(ok), 64'd1);
        @(posedge clock); #1;
        s_rready = 1'b0;
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clock);
            if (s_rvalid) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [1:0]  rs;
        logic [1:0]  bs;
        int          lat;
        bit          ok;
        bit          aw_early;
        logic [63:0] exp_c;

        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[2] = 64'hDEADBEEF_CAFEF00D;
        mem[3] = 64'h5555_5555_5555_5555;
        mem[4] = 64'h0123_4567_89AB_CDEF;
        mem[5] = 64'h0F0F_0F0F_0F0F_0F0F;

        // Reset: inputs requesting everything, outputs must stay quiet.
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        s_bready = 1'b0; s_rready = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_arready", 64'(s_arready), 64'd0);
        check("rst_awready", 64'(s_awready), 64'd0);
        check("rst_wready",  64'(s_wready),  64'd0);
        check("rst_rvalid",  64'(s_rvalid),  64'd0);
        check("rst_bvalid",  64'(s_bvalid),  64'd0);
        check("rst_en",      64'(bram_en),   64'd0);
        check("rst_we",      64'(bram_we),   64'd0);
        check("rst_rdata",   s_rdata,        64'd0);
        check("rst_bresp",   64'(s_bresp),   64'd0);
        check("rst_rresp",   64'(s_rresp),   64'd0);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_arready", 64'(s_arready), 64'd1);
        @(posedge clock); #1;

        // Full-word write then read back.
        axi_write(16'h0008, 64'h1122334455667788, 8'hFF, bs, lat);
        check("w8_bresp", 64'(bs), 64'(WR_EXP));
        check("w8_blat", 64'(lat), 64'(WLAT));
        axi_read(16'h0008, rd, rs, lat);
        check("r8_data", rd, WP ? 64'd0 : 64'h1122334455667788);
        check("r8_rresp", 64'(rs), 64'd0);
        check("r8_rlat", 64'(lat), 64'd2);

        // Low address bits ignored.
        axi_read(16'h000F, rd, rs, lat);
        check("alias_data", rd, WP ? 64'd0 : 64'h1122334455667788);

        // Partial strobe merges into existing word.
        exp_c = WP ? 64'h0123456789ABCDEF : 64'h01234567_BBBBBBBB;
        axi_write(16'h0020, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, bs, lat);
        check("strb_bresp", 64'(bs), 64'(WR_EXP));
        axi_read(16'h0020, rd, rs, lat);
        check("strb_data", rd, exp_c);

        // Zero strobe: response only, storage untouched.
        axi_write(16'h0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, bs, lat);
        check("strb0_bresp", 64'(bs), 64'(WR_EXP));
        axi_read(16'h0018, rd, rs, lat);
        check("strb0_data", rd, 64'h5555_5555_5555_5555);

        // Write to 0x10: overwritten normally, preserved when protected.
        axi_write(16'h0010, 64'h1234_5678_9ABC_DEF0, 8'hFF, bs, lat);
        check("w10_bresp", 64'(bs), 64'(WR_EXP));
        axi_read(16'h0010, rd, rs, lat);
        check("w10_data", rd,
              WP ? 64'hDEADBEEF_CAFEF00D : 64'h1234_5678_9ABC_DEF0);

        // Simultaneous read and write to the same word: read goes first.
        s_araddr = 16'h0028; s_arvalid = 1'b1;
        s_awaddr = 16'h0028; s_wdata = 64'h7777_8888_9999_AAAA;
        s_wstrb = 8'hFF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_rready = 1'b0; s_bready = 1'b0;
        @(negedge clock);
        check("sim_arready", 64'(s_arready), 64'd1);
        check("sim_awready", 64'(s_awready), 64'd0);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        aw_early = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clock);
            if (s_awready) aw_early = 1'b1;
            if (s_rvalid) begin ok = 1'b1; break; end
        end
        check("sim_rvalid", 64'(ok), 64'd1);
        check("sim_aw_early", 64'(aw_early), 64'd0);
        check("sim_rdata", s_rdata, 64'h0F0F_0F0F_0F0F_0F0F);
        @(posedge clock); #1;
        s_rready = 1'b1;
        @(posedge clock); #1;
        s_rready = 1'b0;
        @(negedge clock);
        check("sim_aw_after", 64'(s_awready), 64'd1);
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        ok = 1'b0;
        bs = 2'bxx;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clock);
            if (s_bvalid) begin ok = 1'b1; bs = s_bresp; break; end
        end
        check("sim_bvalid", 64'(ok), 64'd1);
        check("sim_bresp", 64'(bs), 64'(WR_EXP));
        @(posedge clock); #1;
        s_bready = 1'b0;
        axi_read(16'h0028, rd, rs, lat);
        check("sim_final", rd,
              WP ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h7777_8888_9999_AAAA);

        // Back-pressure: response held, new AR not accepted.
        s_araddr = 16'h0020; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clock);
        check("bp_arready0", 64'(s_arready), 64'd1);
        @(posedge clock); #1;
        s_araddr = 16'h0008;
        wait_rvalid(ok);
        check("bp_rvalid_seen", 64'(ok), 64'd1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            check("bp_rvalid", 64'(s_rvalid), 64'd1);
            check("bp_rdata", s_rdata, exp_c);
            check("bp_arready", 64'(s_arready), 64'd0);
        end
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        @(posedge clock); #1;
        s_rready = 1'b0;
        @(negedge clock);
        check("bp_done_rvalid", 64'(s_rvalid), 64'd0);

        // Reset pulse while a read response is pending.
        @(posedge clock); #1;
        s_araddr = 16'h0008; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        wait_rvalid(ok);
        check("rr_rvalid_seen", 64'(ok), 64'd1);
        resetn = 1'b0;
        #1;
        check("rr_rvalid_drop", 64'(s_rvalid), 64'd0);
        check("rr_rdata_clr", s_rdata, 64'd0);
        check("rr_arready", 64'(s_arready), 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        check("rr_arready_up", 64'(s_arready), 64'd1);
        @(posedge clock); #1;
        axi_read(16'h0020, rd, rs, lat);
        check("rr_next_data", rd, exp_c);
        check("rr_next_rresp", 64'(rs), 64'd0);
        check("rr_next_lat", 64'(lat), 64'd2);

        check("we_without_en", 64'(excl_viol), 64'd0);
`ifdef AXIL_BRAM_WPROT_EN
        check("wp_we_seen", 64'(we_seen), 64'd0);
`else
        check("we_seen", 64'(we_seen > 0), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_bram_bridge.md
AXIL_BRAM_BRIDGE -- requirements
Module: axil_bram_bridge

Interface
REQ-001 Parameter ADDR_W, 16: AXI4-Lite byte-address width.
REQ-002 Parameter BRAM_AW, 13: BRAM word-address width (8192 x 64-bit words).
REQ-003 Port clock  input  1  sole clock, all logic on rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Ports s_awvalid/s_awready/s_awaddr[ADDR_W]  in/out/in: AXI-Lite write address channel.
REQ-006 Ports s_wvalid/s_wready/s_wdata[64]/s_wstrb[8]  in/out/in/in: write data channel.
REQ-007 Ports s_bvalid/s_bready/s_bresp[2]  out/in/out: write response channel.
REQ-008 Ports s_arvalid/s_arready/s_araddr[ADDR_W]  in/out/in: read address channel.
REQ-009 Ports s_rvalid/s_rready/s_rdata[64]/s_rresp[2]  out/in/out/out: read data channel.
REQ-010 Ports bram_en/bram_addr[BRAM_AW]/bram_wdata[64]/bram_we[8]  out: downstream BRAM storage port.
REQ-011 Port bram_rdata  input  64  registered BRAM read data, valid one cycle after a read enable.

Function
REQ-012 FSM states IDLE, WRITE, RD_WAIT, RD_RESP, WR_RESP, one-hot or binary.
REQ-013 IDLE: s_arready=1; s_awready=s_wready=1 only when s_awvalid&&s_wvalid&&!s_arvalid.
REQ-014 Simultaneous read and write requests: read wins; write waits, no data lost.
REQ-015 Word address = addr[BRAM_AW+2:3]; addr[2:0] ignored; address bits above BRAM_AW+2 ignored (alias).
REQ-016 AW+W handshake -> WRITE: bram_en=1, bram_we=s_wstrb (registered), bram_wdata=s_wdata for exactly one cycle; then WR_RESP.
REQ-017 s_wstrb==0 still completes with OKAY, BRAM untouched (we all zero).
REQ-018 WR_RESP: s_bvalid=1, s_bresp=OKAY held until s_bready; then IDLE.
REQ-019 AR handshake -> RD_WAIT: bram_en=1, bram_we=0 for one cycle; next cycle capture bram_rdata into holding register, go RD_RESP.
REQ-020 RD_RESP: s_rvalid=1, s_rdata=held word, s_rresp=OKAY stable until s_rready; then IDLE.
REQ-021 bram_en and bram_we are 0 in every state except the single access cycle; never both read and write in one cycle.
REQ-022 Min latency: read AR accept -> rvalid 2 cycles; write accept -> bvalid 2 cycles; one outstanding transaction total.
REQ-023 Back-pressure on rready/bready indefinitely holds response; no new request accepted meanwhile.

Reset
REQ-024 resetn low asynchronously forces IDLE; all valid/ready outputs, bram_en, bram_we to 0; s_rdata, s_bresp, s_rresp to 0.
REQ-025 Reset mid-transaction abandons it; a write already issued in WRITE remains in BRAM, no response generated.
REQ-026 Deassertion first IDLE cycle asserts s_arready=1.

Configuration
REQ-027 Macro AXIL_BRAM_WPROT_EN defined: all writes rejected, bram_we held 0, WRITE state skipped, response SLVERR (2'b10) via WR_RESP.
REQ-028 Macro absent: writes behave per REQ-016..018.

Structure
REQ-029 Shared package axil_bram_pkg: state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10), default widths.
REQ-030 No sub-module; single FSM plus read-holding register.

Verification
REQ-031 Write 0x0000_0008 data 0x1122334455667788 strb 0xFF, then read 0x0008 -> rdata 0x1122334455667788, both resp OKAY.
REQ-032 Write strb 0x0F data 0xAAAAAAAA_BBBBBBBB over word 0x0123456789ABCDEF -> read returns 0x01234567_BBBBBBBB.
REQ-033 arvalid, awvalid, wvalid asserted same cycle -> read completes first, write accepted after rvalid handshake.
REQ-034 Hold s_rready=0 for 10 cycles -> s_rvalid, s_rdata stable, arready=0 throughout.
REQ-035 resetn pulsed low during RD_RESP -> rvalid drops immediately, next read completes normally.
REQ-036 With AXIL_BRAM_WPROT_EN: write to 0x0010 -> bresp SLVERR, subsequent read shows original content.
